// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the decode-stage hazard scheduler.
package hazard_scheduler_pkg;

    localparam int unsigned REG_ADDR   = 5;
    localparam int unsigned WB_OFS_ALU = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // WB slot offset of a multiplier result relative to its issue cycle
    function automatic int unsigned wb_ofs_mul(input int unsigned mul_lat);
        return mul_lat + 2;
    endfunction

    // Bits needed to hold a countdown value up to max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: a register is pending while its count is nonzero.
module hazard_scoreboard
    import hazard_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_val,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    input  logic [ADDR_W-1:0] rd_c_addr,
    output logic              rd_a_pending,
    output logic              rd_b_pending,
    output logic              rd_c_pending,
    output logic              all_clear
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [CNT_W-1:0] cnt [NREG];

    // Count down every busy register; an issue write overrides the decrement. r0 stays idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    cnt[i] <= wr_val;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assign rd_a_pending = (cnt[rd_a_addr] != '0);
    assign rd_b_pending = (cnt[rd_b_addr] != '0);
    assign rd_c_pending = (cnt[rd_c_addr] != '0);

    // Scoreboard is empty when no register has a count in flight
    always_comb begin
        all_clear = 1'b1;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (cnt[i] != '0) begin
                all_clear = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage issue controller: RAW/WAW/WB-port hazard stalls, jump squash, drain/halt.
// Optional perf counters are built when HAZARD_PERF_EN is defined; otherwise they read 0.
module hazard_scheduler #(
    parameter int unsigned MUL_LAT  = 5,
    parameter int unsigned LD_LAT   = 1,
    parameter int unsigned REG_ADDR = hazard_scheduler_pkg::REG_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_src1,
    input  logic [REG_ADDR-1:0] id_src2,
    input  logic                id_uses_src2,
    input  logic [REG_ADDR-1:0] id_dest,
    input  logic                id_regwrite,
    input  logic                id_is_load,
    input  logic                id_is_mult,
    input  logic                id_is_jump,
    input  logic                drain_req,
    output logic                stall,
    output logic                decode_we,
    output logic                pc_we,
    output logic                bubble,
    output logic                flush,
    output logic                drained,
    output logic [31:0]         perf_stalls,
    output logic [31:0]         perf_issued
);

    import hazard_scheduler_pkg::*;

    localparam int unsigned WB_W    = MUL_LAT + 3;
    localparam int unsigned OFS_MUL = wb_ofs_mul(MUL_LAT);
    localparam int unsigned CNT_W   = cnt_width((MUL_LAT > LD_LAT) ? MUL_LAT : LD_LAT);

    state_t            state;
    state_t            state_next;
    logic [WB_W-1:0]   wb_rsv;
    logic [WB_W-1:0]   wb_set;
    logic              valid_eff;
    logic              src1_pend;
    logic              src2_pend;
    logic              dest_pend;
    logic              sb_clear;
    logic              pipe_empty;
    logic              hazard;
    logic              issue;
    logic              sb_we;
    logic [CNT_W-1:0]  sb_val;

    // The slot right after a taken jump is dead regardless of id_valid
    assign valid_eff  = id_valid & ~flush;
    assign pipe_empty = sb_clear & (wb_rsv == '0);

    assign hazard = src1_pend
                  | (id_uses_src2 & src2_pend)
                  | (id_regwrite & dest_pend)
                  | (id_regwrite & (id_is_mult ? wb_rsv[OFS_MUL] : wb_rsv[WB_OFS_ALU]));

    assign sb_we  = issue & id_regwrite & (id_dest != '0);
    assign sb_val = id_is_load ? CNT_W'(LD_LAT) :
                    id_is_mult ? CNT_W'(MUL_LAT) : '0;

    hazard_scoreboard #(
        .ADDR_W (REG_ADDR),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (sb_we),
        .wr_addr      (id_dest),
        .wr_val       (sb_val),
        .rd_a_addr    (id_src1),
        .rd_b_addr    (id_src2),
        .rd_c_addr    (id_dest),
        .rd_a_pending (src1_pend),
        .rd_b_pending (src2_pend),
        .rd_c_pending (dest_pend),
        .all_clear    (sb_clear)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: drain waits for an empty pipe, halt waits for drain_req release
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (drain_req) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (pipe_empty)      state_next = ST_HALTED;
                else if (!drain_req) state_next = ST_RUN;
            end
            ST_HALTED: if (!drain_req) state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // FSM outputs: only RUN may issue; every other state holds decode
    always_comb begin
        stall = 1'b1;
        issue = 1'b0;
        case (state)
            ST_RUN: begin
                stall = valid_eff & hazard;
                issue = valid_eff & ~hazard;
            end
            default: ;
        endcase
    end

    assign decode_we = ~stall;
    assign pc_we     = ~stall;
    assign bubble    = stall | ~valid_eff;

    // WB slot to book for the issuing instruction
    always_comb begin
        wb_set = '0;
        if (issue && id_regwrite) begin
            if (id_is_mult) wb_set[OFS_MUL]    = 1'b1;
            else            wb_set[WB_OFS_ALU] = 1'b1;
        end
    end

    // WB reservation shift, jump squash and drained flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_rsv  <= '0;
            flush   <= 1'b0;
            drained <= 1'b0;
        end else begin
            wb_rsv  <= (wb_rsv | wb_set) >> 1;
            flush   <= issue & id_is_jump;
            drained <= (state_next == ST_HALTED);
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running stall and issue counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stalls <= '0;
            perf_issued <= '0;
        end else begin
            if (stall && id_valid) perf_stalls <= perf_stalls + 32'd1;
            if (issue)             perf_issued <= perf_issued + 32'd1;
        end
    end
`else
    assign perf_stalls = '0;
    assign perf_issued = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_hazard_scheduler;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned LD_LAT  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_src1 = '0;
    logic [4:0]  id_src2 = '0;
    logic        id_uses_src2 = 1'b0;
    logic [4:0]  id_dest = '0;
    logic        id_regwrite = 1'b0;
    logic        id_is_load = 1'b0;
    logic        id_is_mult = 1'b0;
    logic        id_is_jump = 1'b0;
    logic        drain_req = 1'b0;
    logic        stall, decode_we, pc_we, bubble, flush, drained;
    logic [31:0] perf_stalls, perf_issued;

    always #5 clk = ~clk;

    hazard_scheduler #(
        .MUL_LAT  (MUL_LAT),
        .LD_LAT   (LD_LAT),
        .REG_ADDR (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src2 (id_uses_src2),
        .id_dest      (id_dest),
        .id_regwrite  (id_regwrite),
        .id_is_load   (id_is_load),
        .id_is_mult   (id_is_mult),
        .id_is_jump   (id_is_jump),
        .drain_req    (drain_req),
        .stall        (stall),
        .decode_we    (decode_we),
        .pc_we        (pc_we),
        .bubble       (bubble),
        .flush        (flush),
        .drained      (drained),
        .perf_stalls  (perf_stalls),
        .perf_issued  (perf_issued)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: absolute-time bookkeeping of result readiness and WB slot usage
    int          t = 0;
    int          ready [32];
    bit          wb_busy [int];
    int          m_state = 0;      // 0 run, 1 drain, 2 halted
    bit          m_flush = 1'b0;
    bit          m_drained = 1'b0;
    bit          m_stall_last = 1'b0;
    logic [31:0] m_pstalls = '0;
    logic [31:0] m_pissued = '0;

    function automatic bit pend(input logic [4:0] r);
        return (r != 5'd0) && (t < ready[r]);
    endfunction

    // Per-cycle compare and model advance, sampled mid-cycle
    always @(negedge clk) begin
        bit veff, haz, e_stall, e_issue, clear;
        int slot, nxt;
        if (!reset) begin
            foreach (ready[i]) ready[i] = 0;
            wb_busy.delete();
            m_state   = 0;
            m_flush   = 1'b0;
            m_drained = 1'b0;
            m_pstalls = '0;
            m_pissued = '0;
        end
        veff = id_valid && !m_flush;
        slot = t + (id_is_mult ? int'(MUL_LAT) + 2 : 3);
        haz  = pend(id_src1) || (id_uses_src2 && pend(id_src2)) ||
               (id_regwrite && pend(id_dest)) ||
               (id_regwrite && wb_busy.exists(slot));
        e_stall = (m_state != 0) || (veff && haz);
        e_issue = (m_state == 0) && veff && !haz;

        chk("stall", stall, e_stall);
        chk("decode_we", decode_we, !e_stall);
        chk("pc_we", pc_we, !e_stall);
        chk("bubble", bubble, e_stall || !veff);
        chk("flush", flush, m_flush);
        chk("drained", drained, m_drained);
`ifdef HAZARD_PERF_EN
        chk("perf_stalls", perf_stalls, m_pstalls);
        chk("perf_issued", perf_issued, m_pissued);
`else
        chk("perf_stalls", perf_stalls, 0);
        chk("perf_issued", perf_issued, 0);
`endif
        m_stall_last = e_stall;

        if (reset) begin
            if (e_stall && id_valid) m_pstalls = m_pstalls + 32'd1;
            if (e_issue) begin
                m_pissued = m_pissued + 32'd1;
                if (id_regwrite) begin
                    wb_busy[slot] = 1'b1;
                    if (id_dest != 5'd0)
                        ready[id_dest] = t + 1 + (id_is_load ? int'(LD_LAT) :
                                                  id_is_mult ? int'(MUL_LAT) : 0);
                end
            end
            clear = 1'b1;
            foreach (ready[i]) if (ready[i] > t) clear = 1'b0;
            foreach (wb_busy[s]) if (s >= t) clear = 1'b0;
            case (m_state)
                0:       nxt = drain_req ? 1 : 0;
                1:       nxt = clear ? 2 : (drain_req ? 1 : 0);
                default: nxt = drain_req ? 2 : 0;
            endcase
            m_flush   = e_issue && id_is_jump;
            m_drained = (nxt == 2);
            m_state   = nxt;
        end
        t++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input int s1, input int s2, input bit u2, input int d,
                       input bit rw, input bit ld, input bit ml, input bit jp);
        id_valid     = v;
        id_src1      = 5'(s1);
        id_src2      = 5'(s2);
        id_uses_src2 = u2;
        id_dest      = 5'(d);
        id_regwrite  = rw;
        id_is_load   = ld;
        id_is_mult   = ml;
        id_is_jump   = jp;
    endtask

    task automatic idle(input int n);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    // Wait for the presented instruction to issue, counting stall cycles
    task automatic go(input string name, input int exp_stalls);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else n++;
        end
        step();
        if (!done) chk({name, "_timeout"}, 0, 1);
        else chk(name, n, exp_stalls);
    endtask

    initial begin
        int n;
        bit done;
        int drain_left;
        int k;

        // Reset state
        reset = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 1);
        chk("rst_flush", flush, 0);
        chk("rst_drained", drained, 0);
        chk("rst_perf_issued", perf_issued, 0);
        step();
        reset = 1'b1;
        step();

        // Load-use
        put(1, 1, 0, 0, 3, 1, 1, 0, 0); go("ldw_issue", 0);
        put(1, 3, 1, 1, 4, 1, 0, 0, 0); go("load_use_stall", 1);
        idle(10);

        // Mult dependent and independent
        put(1, 1, 2, 1, 5, 1, 0, 1, 0); go("mul_issue", 0);
        put(1, 5, 2, 1, 6, 1, 0, 0, 0); go("mul_dep_stall", 5);
        idle(12);
        put(1, 1, 2, 1, 5, 1, 0, 1, 0); go("mul_issue2", 0);
        put(1, 1, 2, 1, 7, 1, 0, 0, 0); go("indep_after_mul", 0);
        idle(12);

        // WB port collision, MUL_LAT-1 cycles after the mult
        put(1, 1, 2, 1, 5, 1, 0, 1, 0); go("mul_issue3", 0);
        idle(MUL_LAT - 2);
        put(1, 1, 2, 1, 9, 1, 0, 0, 0); go("wb_conflict", 1);
        idle(12);

        // WAW behind a mult
        put(1, 1, 2, 1, 5, 1, 0, 1, 0); go("mul_issue4", 0);
        put(1, 1, 2, 1, 5, 1, 0, 0, 0); go("waw_stall", 5);
        idle(12);

        // Jump squash: the flushed slot is neither issued nor scoreboarded
        put(1, 0, 0, 0, 0, 0, 0, 0, 1); go("jump_issue", 0);
        put(1, 1, 0, 0, 8, 1, 1, 0, 0);
        @(negedge clk);
        chk("flush_set", flush, 1);
        chk("flush_bubble", bubble, 1);
        chk("flush_no_stall", stall, 0);
        step();
        put(1, 8, 1, 1, 10, 1, 0, 0, 0); go("squashed_not_scoreboarded", 0);
        idle(12);

        // Drain with a mult in flight, then resume
        put(1, 1, 2, 1, 5, 1, 0, 1, 0); go("mul_issue5", 0);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain_req = 1'b1;
        n = 0;
        done = 1'b0;
        for (int j = 0; j < 40 && !done; j++) begin
            @(negedge clk);
            if (j == 1) chk("drain_stall", stall, 1);
            if (drained) done = 1'b1;
            else n++;
        end
        if (!done) chk("drain_timeout", 0, 1);
        else chk("drain_cycles", n, MUL_LAT + 3);
        step();
        drain_req = 1'b0;
        put(1, 5, 1, 1, 11, 1, 0, 0, 0); go("resume_after_halt", 1);
        idle(12);

        // Reset mid-mult
        put(1, 1, 2, 1, 12, 1, 0, 1, 0); go("mul_issue6", 0);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_flush", flush, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_perf_stalls", perf_stalls, 0);
        chk("midrst_perf_issued", perf_issued, 0);
        step();
        reset = 1'b1;
        put(1, 12, 1, 1, 13, 1, 0, 0, 0); go("after_reset_no_stall", 0);
        idle(4);

        // Randomized traffic; a stalled instruction is held until it issues
        drain_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!m_stall_last) begin
                k = $urandom_range(0, 99);
                if (k < 45)
                    put($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                        1'($urandom_range(0, 1)), $urandom_range(0, 7), 1, 0, 0, 0);
                else if (k < 65)
                    put($urandom_range(0, 9) != 0, $urandom_range(0, 7), 0, 0,
                        $urandom_range(0, 7), 1, 1, 0, 0);
                else if (k < 78)
                    put($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                        1, $urandom_range(0, 7), 1, 0, 1, 0);
                else if (k < 88)
                    put($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                        1, $urandom_range(0, 7), 0, 0, 0, 0);
                else if (k < 94)
                    put($urandom_range(0, 9) != 0, 0, 0, 0, 0, 0, 0, 0, 1);
                else
                    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            if (drain_left > 0) drain_left--;
            else if ($urandom_range(0, 199) == 0) drain_left = $urandom_range(3, 30);
            drain_req = (drain_left > 0);
            reset = ($urandom_range(0, 999) != 0);
            step();
        end

        reset = 1'b1;
        drain_req = 1'b0;
        idle(4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
